router_sync: RTL and testbench

//  Synchronizer between the router input FSM/register stage and the three output FIFOs of the 1x3 router.
//  - Latches the 2-bit destination address of each packet.
//  - Steers the write strobe to one FIFO and reports that FIFO's full flag back to the FSM.
//  - Drives per-port valid-out from the FIFO empty flags.
//  - Issues a per-FIFO soft reset when a destination leaves its data unread too long.

---
 rtl/router_sync.sv | 108 ++++++++++
 tb/tb_router_sync.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/router_sync.sv
// Address latch, write steering and per-FIFO read-timeout soft reset
// between the router input FSM and its three output FIFOs.
module router_sync #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       detect_add,
    input  logic       write_enb_reg,
    input  logic [1:0] data_in,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam int unsigned NPORT = 3;

    logic [1:0]                  addr_q, addr_d;
    logic [NPORT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NPORT-1:0]            soft_reset_q, soft_reset_d;
    logic [NPORT-1:0]            vld, rd;

    assign vld = ~{empty_2, empty_1, empty_0};
    assign rd  = {read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0    = vld[0];
    assign vld_out_1    = vld[1];
    assign vld_out_2    = vld[2];
    assign soft_reset_0 = soft_reset_q[0];
    assign soft_reset_1 = soft_reset_q[1];
    assign soft_reset_2 = soft_reset_q[2];

    // Destination address capture
    always_comb begin
        addr_d = addr_q;
        if (detect_add) begin
            addr_d = data_in;
        end
    end

    // Write steering and full-flag return use the latched address only
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr_q)
            2'b00: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            2'b01: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            2'b10: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    // Per-port unread-data timeout; wraps to zero as it fires so pulses repeat
    always_comb begin
        cnt_d        = cnt_q;
        soft_reset_d = '0;
        for (int i = 0; i < int'(NPORT); i++) begin
            if (!vld[i] || rd[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
                cnt_d[i]        = '0;
                soft_reset_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q       <= 2'b00;
            cnt_q        <= '0;
            soft_reset_q <= '0;
        end else begin
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: address/steering vector table plus
// hand-written timeout, independence and reset-mid-count sequences.
module tb_router_sync;

    logic       clock = 1'b0;
    logic       resetn;
    logic       detect_add, write_enb_reg;
    logic [1:0] data_in;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int checks = 0;
    int errors = 0;

    router_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
        .clock(clock), .resetn(resetn),
        .detect_add(detect_add), .write_enb_reg(write_enb_reg), .data_in(data_in),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
        .full_0(full_0), .full_1(full_1), .full_2(full_2),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .write_enb(write_enb), .fifo_full(fifo_full),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       det;
        logic       wr;
        logic [1:0] data;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] exp_we;
        logic       exp_ff;
        logic [2:0] exp_vld;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_sr(input string name, input int idx, input logic [2:0] exp);
        chk(name, idx, 32'({soft_reset_2, soft_reset_1, soft_reset_0}), 32'(exp));
    endtask

    // Hold reset for a few edges with everything idle, then release just after an edge
    task automatic do_reset();
        resetn        = 1'b0;
        detect_add    = 1'b0;
        write_enb_reg = 1'b0;
        data_in       = 2'b00;
        {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
        {empty_2, empty_1, empty_0}          = 3'b111;
        {full_2, full_1, full_0}             = 3'b000;
        repeat (3) tick();
        resetn = 1'b1;
    endtask

    initial begin
        // addr starts at 00 after reset
        vecs[0]  = '{1'b0, 1'b1, 2'b00, 3'b000, 3'b000, 3'b001, 1'b0, 3'b111};
        vecs[1]  = '{1'b1, 1'b0, 2'b01, 3'b000, 3'b101, 3'b000, 1'b0, 3'b010};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 3'b010, 3'b010, 3'b010, 1'b1, 3'b101};
        vecs[3]  = '{1'b0, 1'b1, 2'b00, 3'b001, 3'b111, 3'b010, 1'b0, 3'b000};
        vecs[4]  = '{1'b1, 1'b1, 2'b10, 3'b001, 3'b011, 3'b010, 1'b0, 3'b100};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 3'b100, 3'b110, 3'b100, 1'b1, 3'b001};
        vecs[6]  = '{1'b1, 1'b0, 2'b11, 3'b111, 3'b000, 3'b000, 1'b1, 3'b111};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 3'b111, 3'b100, 3'b000, 1'b0, 3'b011};
        vecs[8]  = '{1'b1, 1'b1, 2'b00, 3'b111, 3'b001, 3'b000, 1'b0, 3'b110};
        vecs[9]  = '{1'b0, 1'b1, 2'b00, 3'b111, 3'b000, 3'b001, 1'b1, 3'b111};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 3'b111, 3'b000, 3'b000, 1'b1, 3'b111};

        // Test 1: long reset with FIFOs non-empty and no reads must not pulse
        resetn        = 1'b0;
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        data_in       = 2'b00;
        {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
        {empty_2, empty_1, empty_0}          = 3'b000;
        {full_2, full_1, full_0}             = 3'b000;
        #1;
        chk_sr("reset_sr_early", 0, 3'b000);
        chk("reset_we", 0, 32'(write_enb), 32'(3'b001));
        repeat (35) tick();
        chk_sr("reset_sr_held", 0, 3'b000);
        chk("reset_we", 1, 32'(write_enb), 32'(3'b001));
        chk("reset_ff", 0, 32'(fifo_full), 32'(1'b0));

        // Tests 2/3: address capture, steering, full return, valid-out
        do_reset();
        {read_enb_2, read_enb_1, read_enb_0} = 3'b111;
        for (int i = 0; i < 11; i++) begin
            detect_add    = vecs[i].det;
            write_enb_reg = vecs[i].wr;
            data_in       = vecs[i].data;
            {full_2, full_1, full_0}    = vecs[i].full;
            {empty_2, empty_1, empty_0} = vecs[i].empty;
            #1;
            chk("write_enb", i, 32'(write_enb), 32'(vecs[i].exp_we));
            chk("fifo_full", i, 32'(fifo_full), 32'(vecs[i].exp_ff));
            chk("vld_out", i, 32'({vld_out_2, vld_out_1, vld_out_0}), 32'(vecs[i].exp_vld));
            chk_sr("vec_sr", i, 3'b000);
            tick();
        end

        // Test 4: FIFO 0 left unread pulses on edges 30 and 60 only
        do_reset();
        empty_0 = 1'b0;
        for (int c = 1; c <= 65; c++) begin
            tick();
            chk_sr("timeout_basic", c, (c == 30 || c == 60) ? 3'b001 : 3'b000);
        end

        // Test 5a: a read on edge 20 restarts the count, next pulse at 50
        do_reset();
        empty_0 = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            read_enb_0 = (c == 20);
            tick();
            chk_sr("timeout_read", c, (c == 50) ? 3'b001 : 3'b000);
        end

        // Test 5b: FIFO 0 empty on edge 10 clears the count, next pulse at 40
        do_reset();
        read_enb_0 = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            empty_0 = (c == 10);
            tick();
            chk_sr("timeout_empty", c, (c == 40) ? 3'b001 : 3'b000);
        end

        // Independence: port 1 from edge 1, port 2 from edge 6, port 0 always read
        do_reset();
        {empty_2, empty_1, empty_0} = 3'b100;
        read_enb_0 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            empty_2 = (c < 6);
            tick();
            chk_sr("timeout_indep", c, (c == 30) ? 3'b010 : (c == 35) ? 3'b100 : 3'b000);
        end

        // Test 6: reset after edge 24 clears the count; restart counts from release
        do_reset();
        empty_0 = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            chk_sr("pre_reset", c, 3'b000);
        end
        #2;
        resetn = 1'b0;
        for (int c = 25; c <= 32; c++) begin
            tick();
            chk_sr("in_reset", c, 3'b000);
        end
        resetn = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            tick();
            chk_sr("post_reset", c, (c == 30) ? 3'b001 : 3'b000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
